mem_pipe_simd: RTL

- Parametrised, registered MEM stage for the SIMD AES datapath. It generalises the scalar MEM stage to LANES x 32-bit lanes.
- Contains a LANES-bank interleaved data memory supporting scalar and vector load/store, and per-byte S-box lookup across all lanes. It also provides per-lane Rcon lookup and ALU passthrough.
- The result is selected and registered into a MEM/WB pipeline register with valid/stall/flush control.
- Sits between the EX pipeline register and writeback. It instantiates the existing s_box (4 bytes per instance, LANES instances) and rcon (LANES instances) modules.

---
 rtl/mem_pipe_simd_if.sv | 34 +++
 rtl/mem_pipe_simd.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_pipe_simd_if.sv
// Bundle between the EX pipeline register and the SIMD MEM stage, plus the MEM/WB outputs.
// The master side drives the instruction and sees the result; the slave side is the stage itself.
interface mem_pipe_simd_if #(
    parameter int LANES = 4,
    parameter int TAG_W = 5
);
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic [32*LANES-1:0]   alu_result;
    logic [32*LANES-1:0]   write_data;
    logic                  mem_write;
    logic                  vec_en;
    logic [1:0]            res_sel;
    logic [TAG_W-1:0]      rd_in;
    logic                  reg_write_in;
    logic                  out_valid;
    logic [32*LANES-1:0]   out_data;
    logic [TAG_W-1:0]      rd_out;
    logic                  reg_write_out;
    logic                  align_err;

    modport master (
        output in_valid, stall, flush, alu_result, write_data, mem_write, vec_en,
               res_sel, rd_in, reg_write_in,
        input  out_valid, out_data, rd_out, reg_write_out, align_err
    );

    modport slave (
        input  in_valid, stall, flush, alu_result, write_data, mem_write, vec_en,
               res_sel, rd_in, reg_write_in,
        output out_valid, out_data, rd_out, reg_write_out, align_err
    );
endinterface

// File: rtl/mem_pipe_simd.sv
// SIMD MEM stage: LANES-bank interleaved data memory, per-byte S-box, per-lane Rcon and ALU
// passthrough, selected into a single registered MEM/WB stage with valid/stall/flush control.
module s_box (
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign out_word[8*gi +: 8] = sbox_byte(in_word[8*gi +: 8]);
    end
endmodule

module rcon (
    input  logic [7:0]  idx,
    output logic [31:0] rcon_word
);
    // Round constants for rounds 1..10 in the low byte; any other index yields 0.
    always_comb begin
        rcon_word = 32'h0;
        case (idx)
            8'd1:  rcon_word = 32'h01;
            8'd2:  rcon_word = 32'h02;
            8'd3:  rcon_word = 32'h04;
            8'd4:  rcon_word = 32'h08;
            8'd5:  rcon_word = 32'h10;
            8'd6:  rcon_word = 32'h20;
            8'd7:  rcon_word = 32'h40;
            8'd8:  rcon_word = 32'h80;
            8'd9:  rcon_word = 32'h1b;
            8'd10: rcon_word = 32'h36;
            default: rcon_word = 32'h0;
        endcase
    end
endmodule

module mem_pipe_simd #(
    parameter int LANES  = 4,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int TAG_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    mem_pipe_simd_if.slave bus
);
    localparam int LB   = $clog2(LANES);
    localparam int BW   = (LB > 0) ? LB : 1;
    localparam int ROWS = DEPTH / LANES;
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_SBOX = 2'b10;
    localparam logic [1:0] SEL_RCON = 2'b11;

    logic                   accept;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      bank_full;
    logic [BW-1:0]          bank;
    logic [ADDR_W-LB-1:0]   row;
    logic                   is_access;
    logic [31:0]            bank_rdata [LANES];
    logic [32*LANES-1:0]    sbox_word;
    logic [32*LANES-1:0]    rcon_word;
    logic [32*LANES-1:0]    result_next;
    logic [32*LANES-1:0]    mem_data;

    logic                   valid_reg;
    logic [32*LANES-1:0]    data_reg;
    logic [TAG_W-1:0]       rd_reg;
    logic                   reg_write_reg;
    logic                   align_reg;
    logic                   sel_mem_reg;
    logic                   vec_reg;
    logic [BW-1:0]          bank_reg;

    assign accept    = bus.in_valid & ~bus.stall & ~bus.flush & ~reset;
    assign addr      = bus.alu_result[ADDR_W-1:0];
    assign bank_full = addr & ADDR_W'(LANES - 1);
    assign bank      = bank_full[BW-1:0];
    assign row       = addr[ADDR_W-1:LB];
    assign is_access = bus.mem_write | (bus.res_sel == SEL_MEM);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [31:0] mem [ROWS];
        logic [31:0] rdata_reg;
        logic        we;
        logic [31:0] wdata;

        // Vector accesses hit every bank at the aligned row; scalar ones only the addressed bank.
        assign we    = accept & bus.mem_write & (bus.vec_en | (bank == BW'(gi)));
        assign wdata = bus.vec_en ? bus.write_data[32*gi +: 32] : bus.write_data[31:0];

        // Read-first: a store that also loads returns the pre-write row.
        always_ff @(posedge clk) begin
            if (accept) rdata_reg <= mem[row];
            if (we)     mem[row]  <= wdata;
        end
        assign bank_rdata[gi] = rdata_reg;

        s_box u_s_box (
            .in_word  (bus.alu_result[32*gi +: 32]),
            .out_word (sbox_word[32*gi +: 32])
        );
        rcon u_rcon (
            .idx       (bus.alu_result[32*gi +: 8]),
            .rcon_word (rcon_word[32*gi +: 32])
        );
    end

    always_comb begin
        result_next = bus.alu_result;
        case (bus.res_sel)
            SEL_SBOX: result_next = sbox_word;
            SEL_RCON: result_next = rcon_word;
            default:  result_next = bus.alu_result;
        endcase
    end

    // Memory results bypass data_reg since the bank read registers already hold them.
    always_comb begin
        mem_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (vec_reg) begin
                mem_data[32*i +: 32] = bank_rdata[i];
            end else if (bank_reg == BW'(i)) begin
                mem_data[31:0] = bank_rdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            align_reg     <= 1'b0;
            sel_mem_reg   <= 1'b0;
            vec_reg       <= 1'b0;
            bank_reg      <= '0;
        end else if (bus.flush) begin
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
            align_reg     <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                valid_reg     <= 1'b1;
                data_reg      <= result_next;
                rd_reg        <= bus.rd_in;
                reg_write_reg <= bus.reg_write_in;
                align_reg     <= bus.vec_en & is_access & (|bank_full);
                sel_mem_reg   <= (bus.res_sel == SEL_MEM);
                vec_reg       <= bus.vec_en;
                bank_reg      <= bank;
            end else begin
                valid_reg     <= 1'b0;
                reg_write_reg <= 1'b0;
                align_reg     <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = valid_reg;
    assign bus.out_data      = sel_mem_reg ? mem_data : data_reg;
    assign bus.rd_out        = rd_reg;
    assign bus.reg_write_out = reg_write_reg;
    assign bus.align_err     = align_reg;
endmodule
